iob_parking_scan_ctrl: RTL

//  Scan scheduler and debouncer for the parking-slot sensor bus (SENSOR_IN). It visits one slot per

---
 rtl/iob_parking_scan_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/iob_parking_scan_ctrl.sv
// Parking-slot sensor scanner: round-robin per-slot debounce, occupancy map,
// free-slot count and change-flag interrupt behind an IOb native slave port.
module iob_parking_scan_ctrl #(
  parameter int N_SLOTS = 8,
  parameter int DEB_TH  = 4,
  parameter int DIV_W   = 16,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic [2:0]          addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [3:0]          wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [N_SLOTS-1:0]  sensor_in,
  output logic [N_SLOTS-1:0]  occ,
  output logic                irq
);

  localparam int IDX_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int FREE_W = $clog2(N_SLOTS + 1);
  localparam int CNT_W  = 4;

  function automatic logic [FREE_W-1:0] free_count(input logic [N_SLOTS-1:0] v);
    logic [FREE_W-1:0] n;
    n = FREE_W'(N_SLOTS);
    for (int i = 0; i < N_SLOTS; i++) begin
      n = n - FREE_W'(v[i]);
    end
    return n;
  endfunction

  logic [N_SLOTS-1:0] sync1_r, sync2_r, occ_r, changed_r;
  logic [1:0]         ctrl_r;
  logic [DIV_W-1:0]   scan_div_r, div_r;
  logic [IDX_W-1:0]   idx_r;
  logic [CNT_W-1:0]   cnt_r [N_SLOTS];
  logic [FREE_W-1:0]  free_r;
  logic               irq_r, ready_r;
  logic [DATA_W-1:0]  rdata_r;

  logic               wr_s, rd_s, div_wr_s, scan_run_s, tick_s;
  logic [1:0]         ctrl_nxt_s;
  logic [DIV_W-1:0]   scan_div_nxt_s, div_nxt_s;
  logic [IDX_W-1:0]   idx_nxt_s;
  logic [N_SLOTS-1:0] occ_nxt_s, set_s, clr_s, changed_nxt_s;
  logic [CNT_W-1:0]   cnt_nxt_s [N_SLOTS];
  logic [DATA_W-1:0]  rdata_nxt_s;

  // Register writes and bus read mux
  always_comb begin
    wr_s     = valid & (wstrb != 4'b0000);
    rd_s     = valid & (wstrb == 4'b0000);
    div_wr_s = wr_s & (addr == 3'd4);
    if (wr_s && (addr == 3'd3) && wstrb[0]) begin
      ctrl_nxt_s = wdata[1:0];
    end else begin
      ctrl_nxt_s = ctrl_r;
    end
    scan_div_nxt_s = scan_div_r;
    for (int b = 0; b < DIV_W; b++) begin
      if (div_wr_s && wstrb[b >> 3]) begin
        scan_div_nxt_s[b] = wdata[b];
      end else begin
        scan_div_nxt_s[b] = scan_div_r[b];
      end
    end
    if (wr_s && (addr == 3'd1)) begin
      clr_s = wdata[N_SLOTS-1:0];
    end else begin
      clr_s = {N_SLOTS{1'b0}};
    end
    rdata_nxt_s = {DATA_W{1'b0}};
    if (rd_s) begin
      case (addr)
        3'd0:    rdata_nxt_s = DATA_W'(occ_r);
        3'd1:    rdata_nxt_s = DATA_W'(changed_r);
        3'd2:    rdata_nxt_s = DATA_W'(free_r);
        3'd3:    rdata_nxt_s = DATA_W'(ctrl_r);
        3'd4:    rdata_nxt_s = DATA_W'(scan_div_r);
        default: rdata_nxt_s = {DATA_W{1'b0}};
      endcase
    end else begin
      rdata_nxt_s = {DATA_W{1'b0}};
    end
  end

  // Scan divider, slot pointer and per-slot debounce
  always_comb begin
    // Clearing uses the post-write enable so a 1->0 write takes effect on its own edge.
    scan_run_s = ctrl_r[0] & ctrl_nxt_s[0];
    tick_s     = scan_run_s & ~div_wr_s & (div_r == scan_div_r);
    div_nxt_s  = div_r;
    idx_nxt_s  = idx_r;
    if (!scan_run_s) begin
      div_nxt_s = {DIV_W{1'b0}};
      idx_nxt_s = {IDX_W{1'b0}};
    end else if (div_wr_s) begin
      div_nxt_s = {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_nxt_s = {DIV_W{1'b0}};
      if (idx_r == IDX_W'(N_SLOTS - 1)) begin
        idx_nxt_s = {IDX_W{1'b0}};
      end else begin
        idx_nxt_s = idx_r + IDX_W'(1);
      end
    end else begin
      div_nxt_s = div_r + DIV_W'(1);
    end
    occ_nxt_s = occ_r;
    set_s     = {N_SLOTS{1'b0}};
    for (int i = 0; i < N_SLOTS; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (!scan_run_s) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (tick_s && (idx_r == IDX_W'(i))) begin
        if (sync2_r[i] == occ_r[i]) begin
          cnt_nxt_s[i] = {CNT_W{1'b0}};
        end else if (cnt_r[i] == CNT_W'(DEB_TH - 1)) begin
          occ_nxt_s[i] = ~occ_r[i];
          cnt_nxt_s[i] = {CNT_W{1'b0}};
          set_s[i]     = 1'b1;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
    // A new flip outranks a same-cycle W1C on that bit.
    changed_nxt_s = (changed_r & ~clr_s) | set_s;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r    <= {N_SLOTS{1'b0}};
      sync2_r    <= {N_SLOTS{1'b0}};
      occ_r      <= {N_SLOTS{1'b0}};
      changed_r  <= {N_SLOTS{1'b0}};
      ctrl_r     <= 2'b00;
      scan_div_r <= {DIV_W{1'b0}};
      div_r      <= {DIV_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      free_r     <= FREE_W'(N_SLOTS);
      irq_r      <= 1'b0;
      ready_r    <= 1'b0;
      rdata_r    <= {DATA_W{1'b0}};
      for (int i = 0; i < N_SLOTS; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_r    <= sensor_in;
      sync2_r    <= sync1_r;
      occ_r      <= occ_nxt_s;
      changed_r  <= changed_nxt_s;
      ctrl_r     <= ctrl_nxt_s;
      scan_div_r <= scan_div_nxt_s;
      div_r      <= div_nxt_s;
      idx_r      <= idx_nxt_s;
      free_r     <= free_count(occ_r);
      irq_r      <= ctrl_r[1] & (|changed_r);
      ready_r    <= valid;
      rdata_r    <= rdata_nxt_s;
      for (int i = 0; i < N_SLOTS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign occ   = occ_r;
  assign irq   = irq_r;
  assign ready = ready_r;
  assign rdata = rdata_r;

endmodule
